// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller.
// FETCH_PERF_EN, when defined, adds perf counters to inst_fetch_ctrl.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush.
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             din,
  input  logic                     pop,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;

  assign dout = mem[rp];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= wp + AW'(1);
      end
      if (pop)
        rp <= rp + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch PC sequencer for a 1-cycle-latency instruction SRAM.
// FETCH_PERF_EN adds perf_fetch_cnt / perf_bubble_cnt outputs.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        sram_en,
  output logic [31:0] sram_addr,
  input  logic [31:0] sram_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_exc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  state_t         state;
  state_t         state_n;
  logic [31:0]    pc;
  logic [31:0]    tag;
  logic [31:0]    last_addr;
  logic           inflight;
  logic [CW-1:0]  count;
  logic [CW:0]    credit;
  logic           pop;
  logic           resp_push;
  logic           can_issue;
  logic           issue_rd;
  logic           issue_exc;
  logic           push;
  fetch_entry_t   push_entry;
  fetch_entry_t   head;

  assign pop       = out_valid & out_ready;
  assign resp_push = inflight & ~redirect_valid;

  // Occupancy after this cycle's pop plus the response landing now.
  assign credit = {1'b0, count} - (CW+1)'(pop)
                + (CW+1)'(inflight);

  assign can_issue = (state == FETCH) & ~redirect_valid
                   & (credit < (CW+1)'(BUF_DEPTH));
  assign issue_rd  = can_issue & (pc[1:0] == 2'b00);
  assign issue_exc = can_issue & (pc[1:0] != 2'b00);

  assign sram_en   = issue_rd;
  assign sram_addr = issue_rd ? pc : last_addr;

  // A misaligned pc only follows a redirect, so no read is in flight.
  assign push = resp_push | issue_exc;

  always_comb begin
    push_entry = '0;
    if (resp_push) begin
      push_entry.pc   = tag;
      push_entry.inst = sram_rdata;
    end else begin
      push_entry.pc  = pc;
      push_entry.exc = 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (redirect_valid),
    .push   (push),
    .din    (push_entry),
    .pop    (pop),
    .dout   (head),
    .count  (count)
  );

  assign out_valid = (count != '0);
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  assign out_exc   = head.exc;

  always_comb begin
    state_n = state;
    unique case (state)
      BOOT:    state_n = FETCH;
      FETCH:   if (issue_exc) state_n = HALT;
      HALT:    state_n = HALT;
      default: state_n = BOOT;
    endcase
    if (redirect_valid)
      state_n = FETCH;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      tag       <= '0;
      last_addr <= '0;
      inflight  <= 1'b0;
    end else begin
      state    <= state_n;
      inflight <= issue_rd;
      if (redirect_valid)
        pc <= redirect_pc;
      else if (issue_rd)
        pc <= pc + 32'd4;
      if (issue_rd) begin
        tag       <= pc;
        last_addr <= pc;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (pop)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!out_valid && state != HALT)
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Sequences the synchronous-read instruction SRAM: owns the fetch PC, issues SRAM reads and absorbs their 1-cycle read latency.
- Buffers returned words in a small FIFO and hands {pc, inst, exc} to decode over a valid/ready handshake.
- Handles pipeline redirects (branch/exception) by killing in-flight and buffered fetches.
- Sits between the PC/branch logic and the instruction SRAM; decode is the consumer.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- BUF_DEPTH, 2, output FIFO entries (power of two, >=2).

Ports:
- clk  input  1  system clock, all state on rising edge
- resetn  input  1  asynchronous, active-low reset
- sram_en  output  1  SRAM read enable this cycle
- sram_addr  output  32  byte address; SRAM uses [19:2]
- sram_rdata  input  32  read data, valid the cycle after sram_en
- redirect_valid  input  1  load new fetch PC, flush everything
- redirect_pc  input  32  new fetch PC
- out_valid  output  1  FIFO head valid
- out_ready  input  1  decode accepts head
- out_pc  output  32  PC of head entry
- out_inst  output  32  instruction of head entry (0 when out_exc)
- out_exc  output  1  address-error fetch (pc[1:0] != 0)

Behaviour:
- Reset (async, resetn=0):
  - state=BOOT, pc=RESET_PC, FIFO empty, no read in flight.
  - sram_en=0, out_valid=0, out_pc=0, out_inst=0, out_exc=0.
- States: BOOT, FETCH, HALT.
  - BOOT: one cycle after reset release, no issue, -> FETCH.
  - FETCH: issue when redirect_valid=0 and (fifo_count + inflight) < BUF_DEPTH, where fifo_count counts entries after this cycle's pop.
  - HALT: entered after a misaligned fetch is pushed; no issue until redirect.
- Issue in FETCH, aligned pc:
  - sram_en=1, sram_addr=pc, inflight<=1, tag<=pc, pc<=pc+4 (wraps mod 2^32).
- Issue in FETCH, pc[1:0]!=0:
  - sram_en=0; push {pc, 0, exc=1} directly; state<=HALT.
  - Exception push occupies the issue slot and obeys the same credit rule.
- Response: cycle after issue, if not killed, push {tag, sram_rdata, 0}; inflight<=0.
- sram_addr holds its last value when sram_en=0; sram_rdata is ignored unless a live read is returning.
- Handshake:
  - pop when out_valid & out_ready.
  - out_* stable while out_valid=1 and out_ready=0.
  - Latency from issue to out_valid is 2 cycles when the FIFO is empty.
  - Full throughput of 1 instr/cycle when out_ready stays high.
- Redirect (highest priority, any state):
  - FIFO cleared; in-flight response discarded (not pushed); pc<=redirect_pc; state<=FETCH; no issue that cycle.
  - First new issue is the next cycle.
  - A pop handshake in the same cycle still counts as consumed.
- FIFO:
  - Simultaneous push and pop when full is legal (count unchanged).
  - The credit rule guarantees push never overflows.
  - Pop when empty cannot occur.
- Redirect during BOOT: takes effect, -> FETCH.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_bubble_cnt[31:0], both reset to 0.
  - perf_fetch_cnt increments per pop handshake.
  - perf_bubble_cnt increments each cycle out_valid=0 while state!=HALT.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package fetch_pkg:
  - state enum {BOOT, FETCH, HALT}.
  - RESET_PC default constant.
  - fetch_entry_t struct {pc[31:0], inst[31:0], exc}.
- Sub-module fetch_fifo:
  - BUF_DEPTH-entry synchronous FIFO of fetch_entry_t with push/pop/flush and count.
  - Async active-low reset on the same clk/resetn.

Test Plan:
- Reset release, out_ready=1 -> sram_en first high in cycle 2, addr BFC0_0000, 0004, 0008...; out_pc follows 2 cycles behind, one per cycle.
- out_ready=0 for 5 cycles after first valid -> at most 2 entries buffered, sram_en drops, out_* held; on resume, pcs are contiguous with none lost or duplicated.
- redirect_pc=8000_0100 while a read is in flight and FIFO is full -> old data never appears; next out_pc is 8000_0100 with matching inst.
- redirect_pc=8000_0102 -> single entry out_pc=8000_0102, out_exc=1, out_inst=0; then no sram_en until redirect_pc=8000_0200 resumes fetch.
- pc=FFFF_FFFC fetch -> next sram_addr is 0000_0000 (wrap).
- With FETCH_PERF_EN, 10 accepted fetches plus 3 stall bubbles -> perf_fetch_cnt=10, perf_bubble_cnt counts exactly the out_valid=0 cycles including the BOOT/latency cycles.
